// File: rtl/filter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : package_settings / filter_ctrl_pkg
// Brief   : Project-wide data width plus the shared state encoding, timing
//           constants and configuration clamp helpers for filter_ctrl.
// Rev     : 1.0  initial release
// ============================================================================

package package_settings;
  // Width of the signed filter sample monitored by the controller
  localparam int SIZE_FILTER_DATA = 16;
endpackage

package filter_ctrl_pkg;
  // Cycles the filter is held in reset after every reconfiguration
  localparam int FLUSH_CYCLES = 4;
  // Extra settle cycles on top of the filter's own k+l latency
  localparam int SETTLE_EXTRA = 8;
  // Legal upper bounds of the filter shape parameters
  localparam logic [3:0] K_MAX = 4'd11;
  localparam logic [2:0] L_MAX = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    ARMED  = 3'd4
  } state_t;

  // Zero maps to 1, anything above K_MAX saturates to K_MAX
  function automatic logic [3:0] clamp_k(input logic [3:0] k);
    logic [3:0] r;
    if (k == 4'd0)     r = 4'd1;
    else if (k > K_MAX) r = K_MAX;
    else               r = k;
    return r;
  endfunction

  // Zero maps to 1, anything above L_MAX saturates to L_MAX
  function automatic logic [2:0] clamp_l(input logic [2:0] l);
    logic [2:0] r;
    if (l == 3'd0)     r = 3'd1;
    else if (l > L_MAX) r = L_MAX;
    else               r = l;
    return r;
  endfunction
endpackage
`default_nettype wire

// File: rtl/filter_ctrl_peak_tracker.sv
`default_nettype none
// ============================================================================
// Module  : peak_tracker
// Brief   : Threshold comparison and first-maximum peak/timestamp capture
//           for a pulse that rises above a signed threshold.
// Rev     : 1.0  initial release
// ============================================================================

module peak_tracker
#(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int TS_WIDTH         = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               run_i,
  input  logic                               armed_i,
  input  logic signed [SIZE_FILTER_DATA-1:0] data_i,
  input  logic signed [SIZE_FILTER_DATA-1:0] thr_i,
  input  logic        [TS_WIDTH-1:0]         ts_i,
  output logic                               above_o,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_o,
  output logic        [TS_WIDTH-1:0]         peak_ts_o
);

  logic signed [SIZE_FILTER_DATA-1:0] peak_q, peak_d;
  logic        [TS_WIDTH-1:0]         peak_ts_q, peak_ts_d;

  assign above_o   = (data_i > thr_i);
  assign peak_o    = peak_q;
  assign peak_ts_o = peak_ts_q;

  // Start a pulse on the rising crossing; afterwards only a strictly larger sample replaces the peak
  always_comb begin
    peak_d    = peak_q;
    peak_ts_d = peak_ts_q;
    if (run_i && above_o) begin
      peak_d    = data_i;
      peak_ts_d = ts_i;
    end else if (armed_i && (data_i > peak_q)) begin
      peak_d    = data_i;
      peak_ts_d = ts_i;
    end
  end

  // Peak registers
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q    <= '0;
      peak_ts_q <= '0;
    end else begin
      peak_q    <= peak_d;
      peak_ts_q <= peak_ts_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : filter_ctrl
// Brief   : Configures an external filter (flush + settle sequencing), then
//           detects threshold pulses on its output and reports the peak and
//           its timestamp through a valid/ready event port.
// Rev     : 1.0  initial release
// ============================================================================

module filter_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int SIZE_FILTER_DATA = package_settings::SIZE_FILTER_DATA,
  parameter int TS_WIDTH         = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  // configuration handshake
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic        [3:0]                  cfg_k,
  input  logic        [2:0]                  cfg_l,
  input  logic        [7:0]                  cfg_m1,
  input  logic        [7:0]                  cfg_m2,
  input  logic signed [SIZE_FILTER_DATA-1:0] cfg_thr,
  // filter control
  output logic                               filt_reset,
  output logic        [3:0]                  filt_k,
  output logic        [2:0]                  filt_l,
  output logic        [7:0]                  filt_m1,
  output logic        [7:0]                  filt_m2,
  input  logic signed [SIZE_FILTER_DATA-1:0] filt_data,
  // event output
  output logic                               ev_valid,
  input  logic                               ev_ready,
  output logic signed [SIZE_FILTER_DATA-1:0] ev_peak,
  output logic        [TS_WIDTH-1:0]         ev_ts,
  // status
  output logic        [2:0]                  state_o,
  output logic        [7:0]                  ovf_cnt
);

  localparam logic [TS_WIDTH-1:0] c_TS_ONE = {{(TS_WIDTH-1){1'b0}}, 1'b1};

  state_t                             state_q, state_d;
  logic        [4:0]                  cnt_q, cnt_d;
  logic        [TS_WIDTH-1:0]         ts_q;
  logic        [3:0]                  k_q;
  logic        [2:0]                  l_q;
  logic        [7:0]                  m1_q, m2_q;
  logic signed [SIZE_FILTER_DATA-1:0] thr_q;
  logic                               ev_valid_q;
  logic signed [SIZE_FILTER_DATA-1:0] ev_peak_q;
  logic        [TS_WIDTH-1:0]         ev_ts_q;
  logic        [7:0]                  ovf_q;

  logic                               w_xfer;
  logic                               w_emit;
  logic                               w_above;
  logic        [4:0]                  w_settle_len;
  logic signed [SIZE_FILTER_DATA-1:0] w_peak;
  logic        [TS_WIDTH-1:0]         w_peak_ts;

  // Reset gates cfg_ready so no transfer can be seen while the block is held
  assign cfg_ready  = !reset && ((state_q == IDLE) || (state_q == RUN) || (state_q == ARMED));
  assign w_xfer     = cfg_valid && cfg_ready;
  // Filter stays in reset until configured and during every flush
  assign filt_reset = !((state_q == IDLE) || (state_q == FLUSH));

  assign filt_k   = k_q;
  assign filt_l   = l_q;
  assign filt_m1  = m1_q;
  assign filt_m2  = m2_q;
  assign ev_valid = ev_valid_q;
  assign ev_peak  = ev_peak_q;
  assign ev_ts    = ev_ts_q;
  assign state_o  = state_q;
  assign ovf_cnt  = ovf_q;

  assign w_settle_len = {1'b0, k_q} + {2'b00, l_q} + 5'(SETTLE_EXTRA);

  peak_tracker #(
    .SIZE_FILTER_DATA (SIZE_FILTER_DATA),
    .TS_WIDTH         (TS_WIDTH)
  ) u_peak (
    .clk       (clk),
    .reset     (reset),
    .run_i     (state_q == RUN),
    .armed_i   (state_q == ARMED),
    .data_i    (filt_data),
    .thr_i     (thr_q),
    .ts_i      (ts_q),
    .above_o   (w_above),
    .peak_o    (w_peak),
    .peak_ts_o (w_peak_ts)
  );

  // Sequencing: a config transfer always wins, even over a falling crossing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_emit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_xfer) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (cnt_q == 5'(FLUSH_CYCLES - 1)) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == (w_settle_len - 5'd1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      RUN: begin
        if (w_xfer) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (w_above) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (w_xfer) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (!w_above) begin
          state_d = RUN;
          w_emit  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, timestamp and configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ts_q    <= '0;
      k_q     <= 4'd1;
      l_q     <= 3'd1;
      m1_q    <= '0;
      m2_q    <= '0;
      thr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ts_q    <= w_xfer ? '0 : (ts_q + c_TS_ONE);
      if (w_xfer) begin
        k_q   <= clamp_k(cfg_k);
        l_q   <= clamp_l(cfg_l);
        m1_q  <= cfg_m1;
        m2_q  <= cfg_m2;
        thr_q <= cfg_thr;
      end
    end
  end

  // Event slot: load when free or being drained this cycle, otherwise count the drop
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_valid_q <= 1'b0;
      ev_peak_q  <= '0;
      ev_ts_q    <= '0;
      ovf_q      <= '0;
    end else if (w_emit) begin
      if (!ev_valid_q || ev_ready) begin
        ev_valid_q <= 1'b1;
        ev_peak_q  <= w_peak;
        ev_ts_q    <= w_peak_ts;
      end else if (ovf_q != 8'hFF) begin
        ovf_q <= ovf_q + 8'd1;
      end
    end else if (ev_ready) begin
      ev_valid_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_filter_ctrl
// Brief   : Directed plus randomized self-checking bench for filter_ctrl.
// Rev     : 1.0  initial release
// ============================================================================

module tb_filter_ctrl;

  localparam int W   = 16;
  localparam int TSW = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FLUSH  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_ARMED  = 3'd4;

  logic                clk = 1'b0;
  logic                reset;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [3:0]          cfg_k;
  logic [2:0]          cfg_l;
  logic [7:0]          cfg_m1;
  logic [7:0]          cfg_m2;
  logic signed [W-1:0] cfg_thr;
  logic                filt_reset;
  logic [3:0]          filt_k;
  logic [2:0]          filt_l;
  logic [7:0]          filt_m1;
  logic [7:0]          filt_m2;
  logic signed [W-1:0] filt_data;
  logic                ev_valid;
  logic                ev_ready;
  logic signed [W-1:0] ev_peak;
  logic [TSW-1:0]      ev_ts;
  logic [2:0]          state_o;
  logic [7:0]          ovf_cnt;

  int total = 0;
  int bad   = 0;
  int tb_ts = 0;       // bench's own notion of the DUT timestamp
  int last_m1, last_m2;

  filter_ctrl #(.SIZE_FILTER_DATA(W), .TS_WIDTH(TSW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_k      (cfg_k),
    .cfg_l      (cfg_l),
    .cfg_m1     (cfg_m1),
    .cfg_m2     (cfg_m2),
    .cfg_thr    (cfg_thr),
    .filt_reset (filt_reset),
    .filt_k     (filt_k),
    .filt_l     (filt_l),
    .filt_m1    (filt_m1),
    .filt_m2    (filt_m2),
    .filt_data  (filt_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_peak    (ev_peak),
    .ev_ts      (ev_ts),
    .state_o    (state_o),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // One clock; inputs are changed and outputs read 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    tb_ts++;
  endtask

  task automatic drive(input int v);
    filt_data = W'(v);
    tick();
  endtask

  task automatic do_cfg(input logic [3:0] k, input logic [2:0] l, input int thr);
    cfg_k     = k;
    cfg_l     = l;
    cfg_thr   = W'(thr);
    last_m1   = 8'hA0 + int'(k);
    last_m2   = 8'h30 + int'(l);
    cfg_m1    = 8'(last_m1);
    cfg_m2    = 8'(last_m2);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tb_ts     = 0;
  endtask

  // Count flush/settle cycles until RUN, bounded; expectations from the clamp rules
  task automatic wait_run(input int ek, input int el, input string tag);
    int cyc = 1;
    int fl  = 0;
    int st  = 0;
    check({tag, "_flush_entry"}, state_o, S_FLUSH);
    while (state_o != S_RUN && cyc < 64) begin
      if (filt_reset == 1'b0) fl++;
      if (state_o == S_SETTLE) st++;
      tick();
      cyc++;
    end
    check({tag, "_flush_len"},  fl,  4);
    check({tag, "_settle_len"}, st,  ek + el + 8);
    check({tag, "_run_cycle"},  cyc, 4 + ek + el + 8 + 1);
    check({tag, "_filt_k"},     filt_k,  ek);
    check({tag, "_filt_l"},     filt_l,  el);
    check({tag, "_filt_m1"},    filt_m1, last_m1);
    check({tag, "_filt_m2"},    filt_m2, last_m2);
    check({tag, "_filt_reset_run"}, filt_reset, 1);
  endtask

  initial begin
    int smp[$];
    int sts[$];
    int exp_pk[$];
    int exp_ts[$];
    int got_pk[$];
    int got_ts[$];
    int v, t0, nmin, pk, pts;
    bit armed;

    reset = 1'b1; cfg_valid = 1'b0; ev_ready = 1'b0; filt_data = '0;
    cfg_k = '0; cfg_l = '0; cfg_m1 = '0; cfg_m2 = '0; cfg_thr = '0;

    // ---- reset state
    tick(); tick(); tick();
    check("rst_state",      state_o,    S_IDLE);
    check("rst_filt_reset", filt_reset, 0);
    check("rst_filt_k",     filt_k,     1);
    check("rst_filt_l",     filt_l,     1);
    check("rst_m1",         filt_m1,    0);
    check("rst_m2",         filt_m2,    0);
    check("rst_ev_valid",   ev_valid,   0);
    check("rst_ev_peak",    ev_peak,    0);
    check("rst_ev_ts",      ev_ts,      0);
    check("rst_ovf",        ovf_cnt,    0);
    check("rst_cfg_ready",  cfg_ready,  0);
    reset = 1'b0;
    tick();
    check("post_rst_state", state_o,    S_IDLE);
    check("post_rst_ready", cfg_ready,  1);
    check("post_rst_frst",  filt_reset, 0);

    // ---- basic configuration k=5 l=3 thr=100
    do_cfg(4'd5, 3'd3, 100);
    wait_run(5, 3, "cfg1");

    // ---- ramp: one event, first 200 wins
    ev_ready = 1'b1;
    drive(90);
    drive(120);
    t0 = tb_ts;
    drive(200);
    drive(200);
    drive(150);
    check("ramp_armed",     state_o,  S_ARMED);
    check("ramp_no_ev_yet", ev_valid, 0);
    drive(80);
    check("ramp_ev_valid",  ev_valid, 1);
    check("ramp_ev_peak",   ev_peak,  200);
    check("ramp_ev_ts",     ev_ts,    t0);
    check("ramp_back_run",  state_o,  S_RUN);
    drive(0);
    check("ramp_ev_drain",  ev_valid, 0);

    // ---- random pulses against an array-scan model (ready held high)
    for (int i = 0; i < 240; i++) begin
      v = int'($urandom_range(0, 700)) - 300;
      if (i >= 237) v = -500;
      smp.push_back(v);
      sts.push_back(tb_ts);
      drive(v);
      if (ev_valid) begin
        got_pk.push_back(int'(ev_peak));
        got_ts.push_back(int'(ev_ts));
      end
    end
    armed = 1'b0; pk = 0; pts = 0;
    for (int i = 0; i < smp.size(); i++) begin
      if (!armed) begin
        if (smp[i] > 100) begin armed = 1'b1; pk = smp[i]; pts = sts[i]; end
      end else if (smp[i] <= 100) begin
        exp_pk.push_back(pk); exp_ts.push_back(pts); armed = 1'b0;
      end else if (smp[i] > pk) begin
        pk = smp[i]; pts = sts[i];
      end
    end
    check("rnd_event_count", got_pk.size(), exp_pk.size());
    nmin = (got_pk.size() < exp_pk.size()) ? got_pk.size() : exp_pk.size();
    for (int i = 0; i < nmin; i++) begin
      check($sformatf("rnd_peak_%0d", i), got_pk[i], exp_pk[i]);
      check($sformatf("rnd_ts_%0d", i),   got_ts[i], exp_ts[i]);
    end

    // ---- back-pressure: first event held, rest dropped, counter saturates
    ev_ready = 1'b0;
    t0 = tb_ts;
    drive(150);
    drive(50);
    check("bp_ev_valid", ev_valid, 1);
    check("bp_ev_peak",  ev_peak,  150);
    drive(180);
    drive(50);
    check("bp_ovf_1",     ovf_cnt,  1);
    check("bp_hold_peak", ev_peak,  150);
    check("bp_hold_ts",   ev_ts,    t0);
    check("bp_hold_vld",  ev_valid, 1);
    for (int i = 0; i < 300; i++) begin
      drive(180);
      drive(50);
    end
    check("bp_ovf_sat",    ovf_cnt, 255);
    check("bp_sat_peak",   ev_peak, 150);
    check("bp_sat_ts",     ev_ts,   t0);
    ev_ready = 1'b1;
    tick();
    check("bp_drained",    ev_valid, 0);

    // ---- clamping of out-of-range k/l, and ts cleared by the transfer
    check("clamp_ready", cfg_ready, 1);
    do_cfg(4'd0, 3'd7, 100);
    wait_run(1, 6, "clamp");
    t0 = tb_ts;
    drive(300);
    drive(0);
    check("clamp_ev_peak", ev_peak, 300);
    check("clamp_ev_ts",   ev_ts,   t0);
    tick();
    check("clamp_drained", ev_valid, 0);

    // ---- transfer while ARMED, together with a falling crossing
    drive(500);
    check("xarm_armed", state_o, S_ARMED);
    filt_data = '0;
    do_cfg(4'd2, 3'd1, 50);
    check("xarm_no_event", ev_valid, 0);
    check("xarm_ovf",      ovf_cnt,  255);
    wait_run(2, 1, "xarm");
    check("xarm_still_no_event", ev_valid, 0);
    t0 = tb_ts;
    drive(60);
    drive(40);
    check("xarm_ev_peak", ev_peak, 60);
    check("xarm_ev_ts",   ev_ts,   t0);
    tick();

    // ---- a pending event survives reconfiguration
    ev_ready = 1'b0;
    t0 = tb_ts;
    drive(70);
    drive(40);
    check("pend_valid", ev_valid, 1);
    do_cfg(4'd3, 3'd2, 50);
    check("pend_after_xfer", ev_valid, 1);
    wait_run(3, 2, "pend");
    check("pend_valid_run", ev_valid, 1);
    check("pend_peak",      ev_peak,  70);
    check("pend_ts",        ev_ts,    t0);
    ev_ready = 1'b1;
    tick();
    check("pend_drained", ev_valid, 0);

    // ---- reset during SETTLE
    do_cfg(4'd5, 3'd3, 100);
    for (int i = 0; i < 6; i++) tick();
    check("rs_in_settle", state_o, S_SETTLE);
    reset = 1'b1;
    tick();
    check("rs_state",     state_o,    S_IDLE);
    check("rs_frst",      filt_reset, 0);
    check("rs_filt_k",    filt_k,     1);
    check("rs_filt_l",    filt_l,     1);
    check("rs_m1",        filt_m1,    0);
    check("rs_m2",        filt_m2,    0);
    check("rs_ev_valid",  ev_valid,   0);
    check("rs_ev_peak",   ev_peak,    0);
    check("rs_ev_ts",     ev_ts,      0);
    check("rs_ovf",       ovf_cnt,    0);
    check("rs_cfg_ready", cfg_ready,  0);
    reset = 1'b0;
    tick();
    check("rs_release_ready", cfg_ready, 1);

    // ---- reset during ARMED: pulse abandoned
    do_cfg(4'd1, 3'd1, 100);
    wait_run(1, 1, "ra");
    drive(300);
    check("ra_armed", state_o, S_ARMED);
    reset = 1'b1;
    filt_data = '0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("ra_no_event", ev_valid, 0);
    check("ra_idle",     state_o,  S_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
